// File: rtl/parity_scan_ctrl.sv
// Range sequencer for a 16-word two-bank parity ROM: walks start..end (wrapping),
// checks even parity on each word, counts errors and records the first failing address.
module parity_scan_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              stop_on_err,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_parity,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                stop_q, stop_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                busy_d, done_d, err_flag_d;
  logic [CNT_W-1:0]    err_count_d;
  logic [ADDR_W-1:0]   first_err_addr_d;
  logic                word_err_c;
  logic                last_c;

  // Nine-bit even parity: data reduction must match the stored bit.
  assign word_err_c = (^mem_data) != mem_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      end_q          <= '0;
      stop_q         <= 1'b0;
      mem_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_flag       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state_q        <= state_d;
      end_q          <= end_d;
      stop_q         <= stop_d;
      mem_addr       <= mem_addr_d;
      busy           <= busy_d;
      done           <= done_d;
      err_flag       <= err_flag_d;
      err_count      <= err_count_d;
      first_err_addr <= first_err_addr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    end_d            = end_q;
    stop_d           = stop_q;
    mem_addr_d       = mem_addr;
    busy_d           = busy;
    done_d           = 1'b0;
    err_flag_d       = err_flag;
    err_count_d      = err_count;
    first_err_addr_d = first_err_addr;
    last_c           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          end_d            = end_addr;
          stop_d           = stop_on_err;
          mem_addr_d       = start_addr;
          err_flag_d       = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          busy_d           = 1'b1;
          state_d          = SCAN;
        end
      end
      SCAN: begin
        if (word_err_c) begin
          if (err_count != {CNT_W{1'b1}}) err_count_d = err_count + CNT_W'(1);
          if (!err_flag) begin
            err_flag_d       = 1'b1;
            first_err_addr_d = mem_addr;
          end
        end
        // End of range, abort and stop-on-error all collapse into one exit.
        last_c = (mem_addr == end_q) || abort || (stop_q && word_err_c);
        if (last_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          mem_addr_d = mem_addr + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Self-checking bench: fixed ROM image scenarios plus randomized ROM/range/abort runs
// against a word-list reference model.
module tb_parity_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, stop_on_err;
  logic [3:0] start_addr, end_addr, mem_addr;
  logic [7:0] mem_data;
  logic       mem_parity;
  logic       busy, done, err_flag;
  logic [4:0] err_count;
  logic [3:0] first_err_addr;

  logic [7:0] rom_d [16];
  logic       rom_p [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data   = rom_d[mem_addr];
  assign mem_parity = rom_p[mem_addr];

  parity_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stop_on_err(stop_on_err),
    .start_addr(start_addr), .end_addr(end_addr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_parity(mem_parity), .busy(busy), .done(done),
    .err_flag(err_flag), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_word(input int a);
    return (($countones(rom_d[a]) + int'(rom_p[a])) % 2) != 0;
  endfunction

  // Image: bank0 errors at 2 and 6, bank1 clean.
  task automatic load_fixed_rom();
    for (int a = 0; a < 16; a++) begin
      rom_d[a] = 8'($urandom);
      rom_p[a] = ^rom_d[a];
      if (a == 2 || a == 6) rom_p[a] = ~rom_p[a];
    end
  endtask

  task automatic load_random_rom();
    for (int a = 0; a < 16; a++) begin
      rom_d[a] = 8'($urandom);
      rom_p[a] = 1'($urandom);
    end
  endtask

  // abort_at < 0 means no abort; mid pulses start on scan cycle 1 with a different range.
  task automatic run_scan(input int s, input int e, input bit stop, input int abort_at,
                          input bit mid);
    int words, cnt, first, cyc;
    bit flag;
    int span;
    span = ((e - s + 16) % 16) + 1;
    words = 0; cnt = 0; first = 0; flag = 0;
    for (int i = 0; i < span; i++) begin
      int a;
      a = (s + i) % 16;
      words = i + 1;
      if (bad_word(a)) begin
        if (cnt < 31) cnt++;
        if (!flag) begin flag = 1; first = a; end
      end
      if (stop && bad_word(a)) break;
      if (i == abort_at) break;
    end

    @(negedge clk);
    start = 1'b1; start_addr = 4'(s); end_addr = 4'(e); stop_on_err = stop;
    @(negedge clk);
    start = 1'b0; stop_on_err = ~stop;
    start_addr = 4'(s + 7); end_addr = 4'(e + 5);
    cyc = 0;
    while (busy && cyc < 40) begin
      check("scan_addr", 32'(mem_addr), 32'((s + cyc) % 16));
      check("done_low_in_scan", 32'(done), 32'd0);
      abort = (cyc == abort_at);
      start = mid && (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
    check("busy_cycles", 32'(cyc), 32'(words));
    check("done_pulse", 32'(done), 32'd1);
    check("err_count", 32'(err_count), 32'(cnt));
    check("err_flag", 32'(err_flag), 32'(flag));
    check("first_err_addr", 32'(first_err_addr), 32'(first));
    // start during DONE must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("addr_hold", 32'(mem_addr), 32'((s + words - 1) % 16));
    check("result_hold", 32'(err_count), 32'(cnt));
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; stop_on_err = 1'b0;
    start_addr = '0; end_addr = '0;
    load_fixed_rom();
    repeat (2) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_first", 32'(first_err_addr), 32'd0);
    reset = 1'b1;
    // abort while idle has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);

    run_scan(0, 15, 1'b0, -1, 1'b0);
    run_scan(0, 15, 1'b1, -1, 1'b0);
    run_scan(14, 3, 1'b0, -1, 1'b0);
    run_scan(8, 15, 1'b0, -1, 1'b0);
    run_scan(5, 5, 1'b0, -1, 1'b0);
    run_scan(0, 15, 1'b0, 3, 1'b1);
    run_scan(4, 9, 1'b0, 5, 1'b0);

    // Asynchronous reset mid-scan at address 7
    @(negedge clk);
    start = 1'b1; start_addr = 4'd0; end_addr = 4'd15; stop_on_err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && mem_addr != 4'd7; i++) @(negedge clk);
    check("pre_reset_addr", 32'(mem_addr), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_err_flag", 32'(err_flag), 32'd0);
    check("arst_first", 32'(first_err_addr), 32'd0);
    @(negedge clk);
    check("arst_no_done", 32'(done), 32'd0);
    reset = 1'b1;
    run_scan(1, 6, 1'b0, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int ab;
      load_random_rom();
      ab = int'($urandom_range(0, 24));
      if (ab > 15) ab = -1;
      run_scan(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               1'($urandom), ab, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
